regbank_wb_arbiter: RTL and testbench
=====================================

// Module: regbank_wb_arbiter
// PURPOSE
//  Writeback arbiter directly upstream of the register bank; drives its i_write/i_addr/i_value port.
//  Merges the ALU and memory-load writeback streams through round-robin arbitration and a small in-order FIFO.
//  Issues at most one register write per cycle.
//  Exports a per-register pending mask so issue logic can stall on registers with writes still queued.
// PARAMETERS
//  ADDR_WIDTH  4                register index width; must match the register bank
//  WORD_WIDTH  32               register data width; must match the register bank
//  SIZE        1<<ADDR_WIDTH    number of registers; width of o_pending
//  FIFO_DEPTH  4                queued writeback entries; power of two, >=2
// PORTS
//  i_clk        in   1                     clock; all state changes on posedge
//  i_rst_n      in   1                     asynchronous, active-low reset
//  i_alu_valid  in   1                     ALU writeback request
//  o_alu_ready  out  1                     ALU request accepted this cycle when high with i_alu_valid
//  i_alu_addr   in   ADDR_WIDTH            ALU destination register
//  i_alu_value  in   WORD_WIDTH            ALU result
//  i_mem_valid  in   1                     load writeback request
//  o_mem_ready  out  1                     load request accepted this cycle when high with i_mem_valid
//  i_mem_addr   in   ADDR_WIDTH            load destination register
//  i_mem_value  in   WORD_WIDTH            load data
//  i_hold       in   1                     freeze draining (debug/pipeline hold); accepting continues until full
//  o_write      out  1                     to regbank i_write
//  o_addr       out  ADDR_WIDTH            to regbank i_addr
//  o_value      out  WORD_WIDTH            to regbank i_value
//  o_pending    out  SIZE                  bit r = 1 while any queued entry targets register r
//  o_count      out  $clog2(FIFO_DEPTH)+1  number of queued entries
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty; o_write=0, o_pending=0, o_count=0; RR pointer = MEM.
//    o_addr/o_value reset to 0. Any in-flight entries are discarded.
//  Drain: pop = !empty && !i_hold.
//    o_write = pop; o_addr/o_value = FIFO head.
//    All three are combinational from registered state; never driven from request inputs.
//    The register bank commits the head on the same edge that pops it.
//  Room: room = !full || pop. A pop frees a slot for a same-cycle push when full.
//  Arbitration (ready is combinational from valids, room and RR pointer):
//    Only one valid: that source gets ready=room.
//    Both valid: the source named by the RR pointer gets ready=room, the other gets ready=0.
//    No valid: both readies = room.
//  Accept/push: at most one request accepted per cycle; the accepted {addr,value} is pushed at the tail on that edge.
//  RR pointer: after a contested grant (both valid, one accepted), the pointer moves to the loser.
//    Otherwise it is unchanged.
//  Latency:
//    Accept at edge N into an empty, unheld FIFO -> o_write=1 during cycle N+1 -> regbank updated at edge N+1.
//    Throughput is one write per cycle.
//  Ordering: strict FIFO order.
//    Two queued writes to the same register commit in acceptance order; the last accepted value wins.
//  o_count = pushes - pops. Simultaneous push+pop leaves o_count unchanged.
//    Pointers wrap modulo FIFO_DEPTH; full when o_count==FIFO_DEPTH.
//  o_pending: OR over occupied entries of one-hot(addr), computed from post-edge FIFO state.
//    An entry being popped still counts during its pop cycle.
//  Requesters hold addr/value stable while valid && !ready (not checked by this block).
// TESTING
//  Reset, then single ALU req addr=3 val=0xA5 -> ready=1; next cycle o_write=1 o_addr=3 o_value=0xA5, o_pending[3]=1;
//    following cycle o_count=0, o_pending=0.
//  Both valid every cycle, 6 cycles, after reset -> grants alternate MEM,ALU,MEM,ALU,MEM,ALU;
//    o_write sequence shows the same order one cycle later.
//  i_hold=1, ALU streams 5 reqs, FIFO_DEPTH=4 -> 4 accepted, o_count=4, ready=0 on 5th.
//    Release hold -> 5th accepted on first pop cycle, o_count stays 4 that cycle.
//  Two queued writes to r7 (0x11 then 0x22) under hold -> o_pending[7]=1 until second pops;
//    regbank r7 ends 0x22.
//  Assert i_rst_n=0 mid-cycle with 3 entries queued -> o_write, o_count, o_pending drop to 0 immediately (no clock edge);
//    after release, first grant with both valid goes to MEM.
//  Random ALU/MEM valid and hold, 10k cycles -> scoreboard model matches regbank contents;
//    no lost, duplicated or reordered writes; o_count never exceeds FIFO_DEPTH.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// rtl/regbank_wb_arbiter.sv - round-robin ALU/load writeback arbiter with in-order FIFO feeding the register bank
module regbank_wb_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 32,
  parameter int SIZE       = 1 << ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_alu_valid,
  output logic                          o_alu_ready,
  input  logic [ADDR_WIDTH-1:0]         i_alu_addr,
  input  logic [WORD_WIDTH-1:0]         i_alu_value,
  input  logic                          i_mem_valid,
  output logic                          o_mem_ready,
  input  logic [ADDR_WIDTH-1:0]         i_mem_addr,
  input  logic [WORD_WIDTH-1:0]         i_mem_value,
  input  logic                          i_hold,
  output logic                          o_write,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [WORD_WIDTH-1:0]         o_value,
  output logic [SIZE-1:0]               o_pending,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Round-robin pointer names the source that wins the next contested cycle.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic [ADDR_WIDTH-1:0] addr_q  [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] value_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  src_e                  rr_q, rr_d;

  logic                  full;
  logic                  pop;
  logic                  room;
  logic                  contested;
  logic                  alu_grant;
  logic                  mem_grant;
  logic                  push;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [WORD_WIDTH-1:0] push_value;
  logic [SIZE-1:0]       pending;

  // Drain and arbitration: pop whenever unheld and non-empty; a pop frees a slot for a same-cycle push.
  always_comb begin
    full        = (count_q == DEPTH_C);
    pop         = (count_q != '0) && !i_hold;
    room        = !full || pop;
    contested   = i_alu_valid && i_mem_valid;
    o_alu_ready = room && !(contested && (rr_q == SRC_MEM));
    o_mem_ready = room && !(contested && (rr_q == SRC_ALU));
    alu_grant   = i_alu_valid && o_alu_ready;
    mem_grant   = i_mem_valid && o_mem_ready;
    push        = alu_grant || mem_grant;
    push_addr   = alu_grant ? i_alu_addr  : i_mem_addr;
    push_value  = alu_grant ? i_alu_value : i_mem_value;
  end

  // Next-state for pointers, occupancy and the round-robin winner (loser of a contested grant goes next).
  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (contested && room) begin
      rr_d = (rr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end

  // Control state register; reset discards anything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= SRC_MEM;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  // FIFO storage; cleared on reset so the head (o_addr/o_value) reads zero afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr_q]  <= push_addr;
      value_q[wr_ptr_q] <= push_value;
    end
  end

  // Pending mask: OR of one-hot destinations over occupied slots, head included while it is being popped.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pending[addr_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end
    end
  end

  // Register bank port and status, all driven from registered state only.
  always_comb begin
    o_write   = pop;
    o_addr    = addr_q[rd_ptr_q];
    o_value   = value_q[rd_ptr_q];
    o_pending = pending;
    o_count   = count_q;
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb/tb_regbank_wb_arbiter.sv - self-checking bench for regbank_wb_arbiter
`timescale 1ns/1ps
module tb_regbank_wb_arbiter;

  localparam int DEPTH = 4;
  localparam bit SRC_ALU = 1'b0;
  localparam bit SRC_MEM = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        av = 1'b0, mv = 1'b0, hold = 1'b0;
  logic [3:0]  aa = '0, ma = '0;
  logic [31:0] avl = '0, mvl = '0;
  logic        alu_ready, mem_ready, wr;
  logic [3:0]  waddr;
  logic [31:0] wvalue;
  logic [15:0] pend;
  logic [2:0]  cnt;

  regbank_wb_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(av), .o_alu_ready(alu_ready), .i_alu_addr(aa), .i_alu_value(avl),
    .i_mem_valid(mv), .o_mem_ready(mem_ready), .i_mem_addr(ma), .i_mem_value(mvl),
    .i_hold(hold), .o_write(wr), .o_addr(waddr), .o_value(wvalue),
    .o_pending(pend), .o_count(cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] v;
  } ent_t;

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] avl;
    logic        mv;
    logic [3:0]  ma;
    logic [31:0] mvl;
    logic        e_ar;
    logic        e_mr;
    logic        e_w;
    logic [3:0]  e_addr;
    logic [31:0] e_val;
    logic [2:0]  e_cnt;
    logic [15:0] e_pend;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        q[$];
  bit          rr_m = SRC_MEM;
  logic [31:0] rb [16];
  logic [31:0] model_rb [16];
  vec_t        tbl [11];

  logic        s_ar, s_mr, s_w;
  logic [3:0]  s_addr;
  logic [31:0] s_val;
  logic [2:0]  s_cnt;
  logic [15:0] s_pend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: compare this cycle's outputs against the queue, then record accepted requests.
  task automatic scoreboard();
    int          n;
    logic [15:0] exp_pend;
    logic        exp_w, room, cont;
    ent_t        e;
    n = q.size();
    chk("count", s_cnt, n);
    exp_pend = '0;
    foreach (q[i]) exp_pend[q[i].a] = 1'b1;
    chk("pending", s_pend, exp_pend);
    exp_w = (n > 0) && !hold;
    chk("write", s_w, exp_w);
    if (s_w && n > 0) begin
      e = q.pop_front();
      chk("wb_addr", s_addr, e.a);
      chk("wb_value", s_val, e.v);
      rb[s_addr] = s_val;
    end
    room = (n < DEPTH) || exp_w;
    cont = av && mv;
    if (av) chk("alu_ready", s_ar, room && !(cont && rr_m == SRC_MEM));
    if (mv) chk("mem_ready", s_mr, room && !(cont && rr_m == SRC_ALU));
    if (av && s_ar) begin q.push_back({aa, avl}); model_rb[aa] = avl; end
    if (mv && s_mr) begin q.push_back({ma, mvl}); model_rb[ma] = mvl; end
    if (cont && room) rr_m = ~rr_m;
  endtask

  // One clock cycle: entered at posedge+1, drives inputs, samples at the falling edge.
  task automatic cycle(input logic a_v, input logic [3:0] a_a, input logic [31:0] a_d,
                       input logic m_v, input logic [3:0] m_a, input logic [31:0] m_d,
                       input logic h);
    av = a_v; aa = a_a; avl = a_d;
    mv = m_v; ma = m_a; mvl = m_d;
    hold = h;
    #4;
    s_ar = alu_ready; s_mr = mem_ready; s_w = wr;
    s_addr = waddr; s_val = wvalue; s_cnt = cnt; s_pend = pend;
    scoreboard();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  function automatic vec_t mkv(logic a_v, logic [3:0] a_a, logic [31:0] a_d,
                               logic m_v, logic [3:0] m_a, logic [31:0] m_d,
                               logic ear, logic emr, logic ew, logic [3:0] ea,
                               logic [31:0] ev, logic [2:0] ec, logic [15:0] ep);
    vec_t t;
    t.av = a_v; t.aa = a_a; t.avl = a_d; t.mv = m_v; t.ma = m_a; t.mvl = m_d;
    t.e_ar = ear; t.e_mr = emr; t.e_w = ew; t.e_addr = ea; t.e_val = ev;
    t.e_cnt = ec; t.e_pend = ep;
    return t;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic last_ar, last_mr;
    for (int i = 0; i < 16; i++) begin rb[i] = '0; model_rb[i] = '0; end

    // Single ALU write, then contested round-robin from reset (MEM first).
    tbl[0]  = mkv(1, 4'd3, 32'hA5, 0, 4'd0, 32'h0,  1, 1, 0, 4'd0, 32'h0,  3'd0, 16'h0000);
    tbl[1]  = mkv(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 1, 4'd3, 32'hA5, 3'd1, 16'h0008);
    tbl[2]  = mkv(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 0, 4'd0, 32'h0,  3'd0, 16'h0000);
    tbl[3]  = mkv(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 0, 4'd0, 32'h0,  3'd0, 16'h0000);
    tbl[4]  = mkv(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd2, 32'hB2, 3'd1, 16'h0004);
    tbl[5]  = mkv(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 1, 4'd1, 32'hA1, 3'd1, 16'h0002);
    tbl[6]  = mkv(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd2, 32'hB2, 3'd1, 16'h0004);
    tbl[7]  = mkv(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 0, 1, 1, 4'd1, 32'hA1, 3'd1, 16'h0002);
    tbl[8]  = mkv(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0, 1, 4'd2, 32'hB2, 3'd1, 16'h0004);
    tbl[9]  = mkv(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 1, 4'd1, 32'hA1, 3'd1, 16'h0002);
    tbl[10] = mkv(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 0, 4'd0, 32'h0,  3'd0, 16'h0000);

    #3;
    chk("reset_write", wr, 1'b0);
    chk("reset_count", cnt, 3'd0);
    chk("reset_pending", pend, 16'h0);
    chk("reset_addr", waddr, 4'd0);
    chk("reset_value", wvalue, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[r]) begin
      cycle(tbl[r].av, tbl[r].aa, tbl[r].avl, tbl[r].mv, tbl[r].ma, tbl[r].mvl, 1'b0);
      if (tbl[r].av) chk($sformatf("tbl%0d_alu_ready", r), s_ar, tbl[r].e_ar);
      if (tbl[r].mv) chk($sformatf("tbl%0d_mem_ready", r), s_mr, tbl[r].e_mr);
      chk($sformatf("tbl%0d_write", r), s_w, tbl[r].e_w);
      if (tbl[r].e_w) begin
        chk($sformatf("tbl%0d_addr", r), s_addr, tbl[r].e_addr);
        chk($sformatf("tbl%0d_value", r), s_val, tbl[r].e_val);
      end
      chk($sformatf("tbl%0d_count", r), s_cnt, tbl[r].e_cnt);
      chk($sformatf("tbl%0d_pending", r), s_pend, tbl[r].e_pend);
    end

    // Fill under hold; fifth request waits, then rides in on the first pop.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'(4 + k), 32'h300 + k, 1'b0, 4'd0, 32'd0, 1'b1);
      if (k < 4) chk("hold_fill_ready", s_ar, 1'b1);
      else begin
        chk("hold_full_ready", s_ar, 1'b0);
        chk("hold_full_count", s_cnt, 3'd4);
      end
    end
    cycle(1'b1, 4'd8, 32'h304, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("release_ready", s_ar, 1'b1);
    chk("release_write", s_w, 1'b1);
    chk("release_count", s_cnt, 3'd4);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("push_pop_count", s_cnt, 3'd4);
    idle(5);

    // Same register written twice: pending holds until the second pops, last value wins.
    cycle(1'b1, 4'd7, 32'h11, 1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b1, 4'd7, 32'h22, 1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    chk("r7_pending_held", s_pend[7], 1'b1);
    chk("r7_count_held", s_cnt, 3'd2);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("r7_first_value", s_val, 32'h11);
    chk("r7_pending_first", s_pend[7], 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("r7_second_value", s_val, 32'h22);
    chk("r7_pending_second", s_pend[7], 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("r7_pending_clear", s_pend[7], 1'b0);
    chk("r7_regbank", rb[7], 32'h22);

    // Asynchronous reset mid-cycle with three entries queued.
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'(9 + k), 32'h900 + k, 1'b0, 4'd0, 32'd0, 1'b1);
    av = 1'b0; mv = 1'b0; hold = 1'b0;
    #4;
    chk("pre_reset_write", wr, 1'b1);
    chk("pre_reset_count", cnt, 3'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_write", wr, 1'b0);
    chk("async_reset_count", cnt, 3'd0);
    chk("async_reset_pending", pend, 16'h0);
    q.delete();
    rr_m = SRC_MEM;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'd12, 32'hC0, 1'b1, 4'd13, 32'hD0, 1'b0);
    chk("post_reset_mem_ready", s_mr, 1'b1);
    chk("post_reset_alu_ready", s_ar, 1'b0);
    idle(3);

    // Random traffic; requesters keep a refused request stable.
    for (int i = 0; i < 16; i++) model_rb[i] = rb[i];
    last_ar = 1'b1; last_mr = 1'b1;
    av = 1'b0; mv = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic n_av, n_mv;
      logic [3:0] n_aa, n_ma;
      logic [31:0] n_avl, n_mvl;
      if (av && !last_ar) begin n_av = av; n_aa = aa; n_avl = avl; end
      else begin n_av = ($urandom_range(9) < 6); n_aa = 4'($urandom_range(15)); n_avl = $urandom; end
      if (mv && !last_mr) begin n_mv = mv; n_ma = ma; n_mvl = mvl; end
      else begin n_mv = ($urandom_range(9) < 6); n_ma = 4'($urandom_range(15)); n_mvl = $urandom; end
      cycle(n_av, n_aa, n_avl, n_mv, n_ma, n_mvl, ($urandom_range(9) < 3));
      last_ar = s_ar; last_mr = s_mr;
    end
    idle(8);
    chk("final_count", s_cnt, 3'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("regbank_r%0d", i), rb[i], model_rb[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
